// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner codes,
// debug view and the tie-break rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  typedef struct packed {
    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t last_grant;
    logic       cancel_pend;
  } arb_dbg_t;

  // Ties alternate against the previous grant; a lone requester always wins.
  function automatic arb_owner_t arb_pick(input logic d_ok, input logic if_ok,
                                          input arb_owner_t last);
    if (d_ok && if_ok) return (last == OWN_IF) ? OWN_D : OWN_IF;
    return d_ok ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-macro signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              pipe_stall;

  // Handshake: a requester raises *_req with address/data stable and holds it until
  // its one-cycle *_ack; it drops req the cycle after ack, and req seen high again
  // in IDLE is a new request. if_cancel aborts a pending or in-flight fetch.
  modport slave (
    input  if_req, if_addr, if_cancel, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           pipe_stall
  );

  modport master (
    output if_req, if_addr, if_cancel, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           pipe_stall
  );
endinterface

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Loadable down-counter with a zero flag; times how long mem_en is held per access.
module mem_port_arbiter_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between instruction fetch and the LW/SW data stage,
// holding each access for MEM_LAT cycles and acknowledging it one cycle later.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic     clk,
  input  logic     rst,
  mem_port_arbiter_if.slave bus,
  output arb_dbg_t dbg
);
  localparam int               CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_t        state, next_state;
  arb_owner_t        owner, last_grant, grant_own;
  logic              grant, if_ok, cnt_zero;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata, if_rdata_q, d_rdata_q;
  logic              lat_we, cancel_pend;

  // A fetch raised together with its own cancel is never granted.
  assign if_ok = bus.if_req & ~bus.if_cancel;

  mem_port_arbiter_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (grant),
    .load_val (LAT_INIT),
    .dec      (state == ARB_BUSY),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_own  = arb_pick(bus.d_req, if_ok, last_grant);
    case (state)
      ARB_IDLE: if (bus.d_req || if_ok) begin
        grant      = 1'b1;
        next_state = ARB_BUSY;
      end
      ARB_BUSY: if (cnt_zero) next_state = ARB_DONE;
      ARB_DONE: next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_ack    = 1'b0;
    bus.d_ack     = 1'b0;
    case (state)
      ARB_BUSY: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = (owner == OWN_D) && lat_we;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
      end
      ARB_DONE: begin
        // A cancel arriving in the ack cycle itself still kills the fetch ack.
        bus.if_ack = (owner == OWN_IF) && !cancel_pend && !bus.if_cancel;
        bus.d_ack  = (owner == OWN_D);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_IF;
      last_grant  <= OWN_IF;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_we      <= 1'b0;
      cancel_pend <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (grant) begin
        owner      <= grant_own;
        last_grant <= grant_own;
        lat_addr   <= (grant_own == OWN_D) ? bus.d_addr : bus.if_addr;
        lat_wdata  <= (grant_own == OWN_D) ? bus.d_wdata : '0;
        lat_we     <= (grant_own == OWN_D) && bus.d_we;
      end
      if (state == ARB_BUSY && cnt_zero) begin
        if (owner == OWN_IF) if_rdata_q <= bus.mem_rdata;
        else if (!lat_we)    d_rdata_q  <= bus.mem_rdata;
      end
      if (state == ARB_DONE)
        cancel_pend <= 1'b0;
      else if (state == ARB_BUSY && owner == OWN_IF && bus.if_cancel)
        cancel_pend <= 1'b1;
    end
  end

  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.pipe_stall = (bus.d_req & ~bus.d_ack) |
                          (bus.if_req & ~bus.if_ack & ~bus.if_cancel);
  assign dbg = {state, owner, last_grant, cancel_pend};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked
// against an access-schedule model and a small behavioural memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 2;

  // ---------------- clock / reset ----------------
  logic     clk = 1'b0;
  logic     rst = 1'b1;
  arb_dbg_t dbg;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .dbg (dbg)
  );

  always #5 clk = ~clk;

  // ---------------- memory macro model ----------------
  // Data is only valid on the MEM_LAT-th consecutive enabled cycle; junk otherwise.
  logic [DATA_W-1:0] mem_arr [16];
  logic [DATA_W-1:0] junk = '0;
  int                en_run = 0;

  always @(posedge clk) begin
    junk   <= DATA_W'($urandom);
    en_run <= bus.mem_en ? en_run + 1 : 0;
  end

  always @(posedge clk)
    if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[3:0]] = bus.mem_wdata;

  always_comb
    bus.mem_rdata = (bus.mem_en && en_run == MEM_LAT - 1) ? mem_arr[bus.mem_addr[3:0]] : junk;

  // ---------------- scoreboard ----------------
  int                n_chk = 0;
  int                n_err = 0;
  int                cyc = 0;
  logic [DATA_W:0]   exp_q[$];   // {owner_is_d, expected rdata} per expected ack

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // One access in flight: granted at cycle m_g, memory held m_g+1..m_g+MEM_LAT,
  // ack at m_g+MEM_LAT+1, next grant possible from m_g+MEM_LAT+2.
  logic [DATA_W-1:0] model_mem [16];
  bit                m_act = 1'b0;
  int                m_g = 0;
  arb_owner_t        m_own = OWN_IF;
  arb_owner_t        m_last = OWN_IF;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wd = '0;
  bit                m_we = 1'b0;
  bit                m_canc = 1'b0;
  logic [DATA_W-1:0] e_if_rd = '0;
  logic [DATA_W-1:0] e_d_rd = '0;

  task automatic check_cycle();
    bit busy, done, e_ifa, e_da, e_stall, if_ok, free;
    logic [DATA_W:0] e;
    int idx;
    busy = m_act && cyc >= m_g + 1 && cyc <= m_g + MEM_LAT;
    done = m_act && cyc == m_g + MEM_LAT + 1;
    if (m_own == OWN_IF && (busy || done) && bus.if_cancel) m_canc = 1'b1;
    e_ifa   = done && m_own == OWN_IF && !m_canc;
    e_da    = done && m_own == OWN_D;
    e_stall = (bus.d_req && !e_da) || (bus.if_req && !e_ifa && !bus.if_cancel);

    chk("state", dbg.state, busy ? ARB_BUSY : (done ? ARB_DONE : ARB_IDLE));
    chk("mem_en", bus.mem_en, busy);
    chk("mem_we", bus.mem_we, busy && m_own == OWN_D && m_we);
    if (busy) chk("mem_addr", bus.mem_addr, m_addr);
    if (busy && m_we) chk("mem_wdata", bus.mem_wdata, m_wd);
    chk("if_ack", bus.if_ack, e_ifa);
    chk("d_ack", bus.d_ack, e_da);
    chk("pipe_stall", bus.pipe_stall, e_stall);
    chk("d_rdata", bus.d_rdata, e_d_rd);

    if (e_ifa) exp_q.push_back({1'b0, e_if_rd});
    if (e_da)  exp_q.push_back({1'b1, e_d_rd});
    if (bus.if_ack || bus.d_ack) begin
      if (exp_q.size() == 0) chk("ack_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        if (bus.d_ack) chk("ack_data", {1'b1, bus.d_rdata}, e);
        else           chk("ack_data", {1'b0, bus.if_rdata}, e);
      end
    end

    idx = int'(m_addr[3:0]);
    if (busy && m_own == OWN_D && m_we) model_mem[idx] = m_wd;
    if (rst) begin
      m_act = 1'b0; m_last = OWN_IF; m_canc = 1'b0;
      e_if_rd = '0; e_d_rd = '0;
    end else begin
      if (busy && cyc == m_g + MEM_LAT) begin
        if (m_own == OWN_IF) e_if_rd = model_mem[idx];
        else if (!m_we)      e_d_rd  = model_mem[idx];
      end
      free  = !m_act || cyc >= m_g + MEM_LAT + 2;
      if_ok = bus.if_req && !bus.if_cancel;
      if (free && (bus.d_req || if_ok)) begin
        if (bus.d_req && if_ok) m_own = (m_last == OWN_IF) ? OWN_D : OWN_IF;
        else                    m_own = bus.d_req ? OWN_D : OWN_IF;
        m_act  = 1'b1;
        m_g    = cyc;
        m_canc = 1'b0;
        m_last = m_own;
        m_addr = (m_own == OWN_D) ? bus.d_addr : bus.if_addr;
        m_we   = (m_own == OWN_D) && bus.d_we;
        m_wd   = bus.d_wdata;
      end
    end
  endtask

  // ---------------- driver ----------------
  bit                if_want = 0, d_want = 0, d_we_v = 0, cancel_now = 0;
  bit                if_hold = 0, d_hold = 0, rand_mode = 0, cont_mode = 0;
  logic [ADDR_W-1:0] if_a = '0, d_a = '0;
  logic [DATA_W-1:0] d_wd = '0;
  int                if_ack_cyc = -100, d_ack_cyc = -100;
  bit                ack_own_q[$];   // 1 = data ack

  task automatic drive();
    if (rand_mode) begin
      if (!if_want && !if_hold && $urandom_range(0, 3) == 0) begin
        if_want = 1'b1; if_a = ADDR_W'($urandom);
      end
      if (!d_want && !d_hold && $urandom_range(0, 3) == 0) begin
        d_want = 1'b1; d_we_v = 1'($urandom_range(0, 1));
        d_a = ADDR_W'($urandom); d_wd = DATA_W'($urandom);
      end
      cancel_now = if_want && $urandom_range(0, 9) == 0;
    end
    if (cont_mode) begin
      if (!if_want && !if_hold) if_want = 1'b1;
      if (!d_want && !d_hold) begin d_want = 1'b1; d_we_v = 1'b0; end
    end
    if_hold = 1'b0;
    d_hold  = 1'b0;
    bus.if_req    = if_want;
    bus.if_addr   = if_a;
    bus.if_cancel = cancel_now;
    bus.d_req     = d_want;
    bus.d_we      = d_we_v;
    bus.d_addr    = d_a;
    bus.d_wdata   = d_wd;
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic step();
    drive();
    #2;
    check_cycle();
    if (bus.if_ack) begin if_want = 0; if_hold = 1; if_ack_cyc = cyc; ack_own_q.push_back(1'b0); end
    if (bus.d_ack)  begin d_want = 0;  d_hold = 1;  d_ack_cyc = cyc;  ack_own_q.push_back(1'b1); end
    if (cancel_now) begin if_a = ADDR_W'($urandom); cancel_now = 1'b0; end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && (if_want || d_want); i++) step();
    if (if_want || d_want) begin
      chk(tag, 1, 0);
      if_want = 1'b0; d_want = 1'b0;
    end
    step();
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    for (int i = 0; i < 16; i++) begin
      mem_arr[i]   = DATA_W'($urandom);
      model_mem[i] = mem_arr[i];
    end
    mem_arr[0]   = 16'hA5A5;
    model_mem[0] = 16'hA5A5;

    @(posedge clk); #1;
    rst = 1'b1; step(); step(); rst = 1'b0;
    chk("rst_state", dbg.state, ARB_IDLE);
    chk("rst_last_grant", dbg.last_grant, OWN_IF);
    chk("rst_cancel_pend", dbg.cancel_pend, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);

    // lone fetch
    if_want = 1; if_a = 16'h0010; t0 = cyc;
    wait_idle("t1_timeout");
    chk("t1_if_lat", if_ack_cyc - t0, 3);
    chk("t1_if_rdata", bus.if_rdata, 16'hA5A5);

    // simultaneous data load and fetch right after reset
    rst = 1'b1; step(); rst = 1'b0;
    d_want = 1; d_we_v = 0; d_a = 16'h0040; if_want = 1; if_a = 16'h0022; t0 = cyc;
    wait_idle("t2_timeout");
    chk("t2_d_lat", d_ack_cyc - t0, 3);
    chk("t2_if_lat", if_ack_cyc - t0, 7);
    chk("t2_d_rdata", bus.d_rdata, 16'hA5A5);

    // store
    d_want = 1; d_we_v = 1; d_a = 16'h0100; d_wd = 16'h1234; t0 = cyc;
    wait_idle("t3_timeout");
    chk("t3_d_lat", d_ack_cyc - t0, 3);
    chk("t3_d_rdata_hold", bus.d_rdata, 16'hA5A5);
    chk("t3_mem_write", mem_arr[0], 16'h1234);

    // fetch cancelled one cycle after grant, then re-served
    if_want = 1; if_a = 16'h0003; t0 = cyc; if_ack_cyc = -100;
    step();
    cancel_now = 1'b1;
    wait_idle("t4_timeout");
    chk("t4_if_lat", if_ack_cyc - t0, 7);

    // reset during a store
    d_want = 1; d_we_v = 1; d_a = 16'h0005; d_wd = 16'hBEEF; d_ack_cyc = -100;
    step();
    rst = 1'b1; d_want = 0; step(); rst = 1'b0;
    chk("t5_mem_en", bus.mem_en, 0);
    chk("t5_mem_we", bus.mem_we, 0);
    chk("t5_state", dbg.state, ARB_IDLE);
    chk("t5_last_grant", dbg.last_grant, OWN_IF);
    repeat (4) step();
    chk("t5_no_ack", d_ack_cyc, -100);

    // both requesters continuously busy
    ack_own_q.delete();
    cont_mode = 1'b1;
    repeat (24) step();
    cont_mode = 1'b0;
    wait_idle("t6_timeout");
    chk("t6_ack_count", ack_own_q.size() >= 6, 1);
    for (int i = 0; i < ack_own_q.size(); i++)
      chk("t6_alternate", ack_own_q[i], (i % 2 == 0));

    // random traffic with cancels
    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    wait_idle("rand_drain");
    chk("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
